dircc_avalon_st_packet_sender: RTL

Serializer feeding the DiRCC Avalon-ST packet fabric: accepts one `packet_t` (from `dircc_types_pkg`) per handshake from the device/application side and emits it as an 8-word, 32-bit Avalon-ST packet with SOP/EOP framing. It is the source-side counterpart of `dircc_avalon_st_packet_receiver`. Its word order is bit-exact with the receiver's deserialization, so sender → receiver round-trips any packet unchanged.

---
 rtl/dircc_avalon_st_packet_sender_if.sv | 29 ++
 rtl/dircc_avalon_st_packet_sender.sv | 113 +++++++++++
 2 files changed

// File: rtl/dircc_avalon_st_packet_sender_if.sv
// dircc_avalon_st_packet_sender_if: request side and Avalon-ST source side of the packet sender.
// master = the sender itself, slave = whoever feeds requests and sinks the stream.
interface dircc_avalon_st_packet_sender_if #(
  parameter int WORD_WIDTH     = 32,
  parameter int EMPTY_WIDTH    = 2,
  parameter int DROP_CNT_WIDTH = 8
);
  logic                      send_packet;
  logic [239:0]              packet_data;
  logic                      packet_ready;
  logic                      send_done;
  logic [DROP_CNT_WIDTH-1:0] dropped_count;
  logic [WORD_WIDTH-1:0]     out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_startofpacket;
  logic                      out_endofpacket;
  logic [EMPTY_WIDTH-1:0]    out_empty;
  modport master (
    input  send_packet, packet_data, out_ready,
    output packet_ready, send_done, dropped_count,
           out_data, out_valid, out_startofpacket, out_endofpacket, out_empty
  );
  modport slave (
    output send_packet, packet_data, out_ready,
    input  packet_ready, send_done, dropped_count,
           out_data, out_valid, out_startofpacket, out_endofpacket, out_empty
  );
endinterface

// File: rtl/dircc_avalon_st_packet_sender.sv
// dircc_avalon_st_packet_sender: serializes one 240-bit packet_t into an 8-word SOP/EOP Avalon-ST packet.
// Optional macro DIRCC_PACKET_SENDER_BUFFER_EN adds a one-packet buffer so back-to-back packets
// stream with no idle cycle between EOP and the next SOP.
// packet_t layout (MSB first): dest{hw 32, sw 16, port 7, flag 1}, src{same}, lamport 32, data 96.
module dircc_avalon_st_packet_sender #(
  parameter int WORD_WIDTH     = 32,
  parameter int EMPTY_WIDTH    = 2,
  parameter int DROP_CNT_WIDTH = 8
) (
  input logic                          clk,
  input logic                          reset_n,
  dircc_avalon_st_packet_sender_if.master bus
);
  if (WORD_WIDTH != 32) begin : g_width_check
    $error("dircc_avalon_st_packet_sender supports WORD_WIDTH = 32 only");
  end
  typedef enum logic {IDLE, SEND} state_t;
  state_t                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [239:0]              hold_q, hold_d;
  logic                      done_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic                      valid, ready, accept, xfer, last;
  logic [31:0]               words [8];
`ifdef DIRCC_PACKET_SENDER_BUFFER_EN
  logic [239:0]              buf_q, buf_d;
  logic                      full_q, full_d;
  assign ready = state_q == IDLE || !full_q;
`else
  assign ready = state_q == IDLE;
`endif
  assign valid  = state_q == SEND;
  assign accept = bus.send_packet && ready;
  assign xfer   = valid && bus.out_ready;
  assign last   = xfer && idx_q == 3'd7;
  assign words[0] = hold_q[239:208];
  assign words[1] = {hold_q[207:184], 8'h00};
  assign words[2] = hold_q[183:152];
  assign words[3] = {hold_q[151:128], 8'h00};
  assign words[4] = hold_q[127:96];
  assign words[5] = hold_q[31:0];
  assign words[6] = hold_q[63:32];
  assign words[7] = hold_q[95:64];
  assign bus.packet_ready      = ready;
  assign bus.out_valid         = valid;
  assign bus.out_data          = valid ? words[idx_q] : 32'h0;
  assign bus.out_startofpacket = valid && idx_q == 3'd0;
  assign bus.out_endofpacket   = valid && idx_q == 3'd7;
  assign bus.out_empty         = {EMPTY_WIDTH{1'b0}};
  assign bus.send_done         = done_q;
  assign bus.dropped_count     = drop_q;
  // Next state: load on accept from IDLE, advance the word index on each transfer, chain buffered packets on EOP.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
`ifdef DIRCC_PACKET_SENDER_BUFFER_EN
    buf_d   = buf_q;
    full_d  = full_q;
`endif
    if (state_q == IDLE) begin
      if (accept) begin
        hold_d  = bus.packet_data;
        idx_d   = 3'd0;
        state_d = SEND;
      end
    end else begin
      if (xfer) idx_d = idx_q + 3'd1;
      if (last) state_d = IDLE;
`ifdef DIRCC_PACKET_SENDER_BUFFER_EN
      if (last && full_q) begin
        hold_d  = buf_q;
        full_d  = 1'b0;
        state_d = SEND;
      end else if (last && accept) begin
        hold_d  = bus.packet_data;
        state_d = SEND;
      end else if (accept) begin
        buf_d  = bus.packet_data;
        full_d = 1'b1;
      end
`endif
    end
  end
  // State registers, done pulse and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      done_q  <= last;
      drop_q  <= (bus.send_packet && !ready && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
    end
  end
`ifdef DIRCC_PACKET_SENDER_BUFFER_EN
  // Second-packet buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
    end
  end
`endif
endmodule
